// File: rtl/tti_rx_byte_packer.sv
// TTI RX byte packer: packs the byte-wide rx_queue write stream into RX data FIFO words.
// Define I3C_RX_PACKER_BIG_ENDIAN_EN to place the first byte of each word in the top lane.
module tti_rx_byte_packer #(
    parameter int unsigned TtiRxDataWidth = 8,
    parameter int unsigned TtiRxFifoWidth = 32,
    parameter int unsigned FrameLenWidth  = 16,
    localparam int unsigned Lanes         = TtiRxFifoWidth / 8,
    localparam int unsigned BytesWidth    = $clog2(Lanes) + 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      byte_wvalid_i,
    output logic                      byte_wready_o,
    input  logic [TtiRxDataWidth-1:0] byte_wdata_i,
    input  logic                      byte_wflush_i,
    output logic                      word_wvalid_o,
    input  logic                      word_wready_i,
    output logic [TtiRxFifoWidth-1:0] word_wdata_o,
    output logic [BytesWidth-1:0]     word_wbytes_o,
    output logic                      word_wlast_o,
    output logic                      frame_done_o,
    output logic [FrameLenWidth-1:0]  frame_len_o,
    output logic                      overflow_o
);

    if (TtiRxDataWidth != 8) begin : gen_bad_data_width
        $error("tti_rx_byte_packer: TtiRxDataWidth must be 8");
    end
    if (TtiRxFifoWidth == 0 || (TtiRxFifoWidth % 8) != 0) begin : gen_bad_fifo_width
        $error("tti_rx_byte_packer: TtiRxFifoWidth must be a non-zero multiple of 8");
    end

    typedef enum logic [0:0] {
        StFill,
        StHold
    } state_e;

    state_e                    state_q;
    logic [TtiRxFifoWidth-1:0] acc_q;
    logic [BytesWidth-1:0]     lane_q;
    logic [FrameLenWidth-1:0]  count_q;
    logic                      flush_pend_q;
    logic                      word_valid_q;
    logic [TtiRxFifoWidth-1:0] word_data_q;
    logic [BytesWidth-1:0]     word_bytes_q;
    logic                      word_last_q;
    logic [FrameLenWidth-1:0]  frame_len_q;
    logic                      zero_done_q;
    logic                      overflow_q;

    logic                      accept;
    logic                      flush_eff;
    logic [TtiRxFifoWidth-1:0] acc_next;
    logic [BytesWidth-1:0]     lane_next;
    logic [FrameLenWidth-1:0]  count_next;
    logic                      emit;
    logic                      zero_close;
    logic                      handshake;
    logic                      last_close;

    always_comb begin
        accept    = byte_wvalid_i && (state_q == StFill);
        // A flush latched during HOLD acts on the first FILL cycle after the handshake.
        flush_eff = byte_wflush_i || flush_pend_q;

        acc_next = acc_q;
        for (int unsigned k = 0; k < Lanes; k++) begin
            if (accept && (lane_q == BytesWidth'(k))) begin
`ifdef I3C_RX_PACKER_BIG_ENDIAN_EN
                acc_next[TtiRxFifoWidth-1-8*k -: 8] = byte_wdata_i;
`else
                acc_next[8*k +: 8] = byte_wdata_i;
`endif
            end
        end

        lane_next = lane_q + BytesWidth'(accept);

        count_next = count_q;
        if (accept && (count_q != '1)) begin
            count_next = count_q + FrameLenWidth'(1);
        end

        emit = (state_q == StFill) &&
               ((accept && (lane_next == BytesWidth'(Lanes))) ||
                (flush_eff && (lane_next != '0)));

        // Flush with nothing buffered closes an open frame without emitting a word.
        zero_close = (state_q == StFill) && flush_eff && (lane_next == '0) && (count_q != '0);

        handshake  = (state_q == StHold) && word_wready_i;
        last_close = handshake && word_last_q && !rst_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StFill;
            acc_q        <= '0;
            lane_q       <= '0;
            count_q      <= '0;
            flush_pend_q <= 1'b0;
            word_valid_q <= 1'b0;
            word_data_q  <= '0;
            word_bytes_q <= '0;
            word_last_q  <= 1'b0;
            frame_len_q  <= '0;
            zero_done_q  <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            zero_done_q <= 1'b0;
            if (byte_wvalid_i && (state_q != StFill)) begin
                overflow_q <= 1'b1;
            end

            unique case (state_q)
                StFill: begin
                    flush_pend_q <= 1'b0;
                    count_q      <= count_next;
                    if (emit) begin
                        word_valid_q <= 1'b1;
                        word_data_q  <= acc_next;
                        word_bytes_q <= lane_next;
                        word_last_q  <= flush_eff;
                        acc_q        <= '0;
                        lane_q       <= '0;
                        state_q      <= StHold;
                    end else begin
                        acc_q  <= acc_next;
                        lane_q <= lane_next;
                        if (zero_close) begin
                            frame_len_q <= count_q;
                            zero_done_q <= 1'b1;
                            count_q     <= '0;
                        end
                    end
                end
                StHold: begin
                    if (byte_wflush_i) begin
                        flush_pend_q <= 1'b1;
                    end
                    if (word_wready_i) begin
                        word_valid_q <= 1'b0;
                        state_q      <= StFill;
                        if (word_last_q) begin
                            frame_len_q <= count_q;
                            count_q     <= '0;
                        end
                    end
                end
                default: begin
                    state_q <= StFill;
                end
            endcase
        end
    end

    assign byte_wready_o = (state_q == StFill);
    assign word_wvalid_o = word_valid_q;
    assign word_wdata_o  = word_data_q;
    assign word_wbytes_o = word_bytes_q;
    assign word_wlast_o  = word_last_q;
    // The closing word's handshake reports the frame in the same cycle.
    assign frame_done_o  = zero_done_q || last_close;
    assign frame_len_o   = last_close ? count_q : frame_len_q;
    assign overflow_o    = overflow_q;

endmodule
